lock_sequencer: RTL and testbench

Sequential controller wrapped around the team's combinational code-match lock. It collects a multi-step code entered on the 6-bit switch bank, one step per `enter` strobe, and drives a timed `unlock` pulse when every step matches. It counts consecutive failures and enforces a lockout period. Code words are held in a small programmable register file and can be rewritten only while the lock is idle.

---
 rtl/lock_pkg.sv | 25 ++
 rtl/lock_sequencer_code_match.sv | 14 +
 rtl/lock_sequencer.sv | 156 +++++++++++++++
 tb/tb_lock_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and default constants for the code-lock sequencer.
package lock_pkg;

    // Default parameter values for the sequencer.
    localparam int LOCK_CODE_W      = 6;
    localparam int LOCK_STEPS       = 3;
    localparam int LOCK_MAX_FAIL    = 3;
    localparam int LOCK_OPEN_CYC    = 50;
    localparam int LOCK_LOCKOUT_CYC = 1000;
    localparam int LOCK_ENTRY_TO    = 500;

    // One code word as entered on the switch bank.
    typedef logic [LOCK_CODE_W-1:0] code_t;

    localparam code_t LOCK_DEFAULT_CODE = 6'b100101;

    // Sequencer states: IDLE has no entry in progress, COLLECT has step > 0.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_OPEN,
        ST_LOCKOUT
    } state_t;

endpackage

// File: rtl/lock_sequencer_code_match.sv
// Combinational equality of the switch word against the selected code word.
module code_match
    import lock_pkg::*;
#(
    parameter int CODE_W = LOCK_CODE_W
) (
    input  logic [CODE_W-1:0] sw,
    input  logic [CODE_W-1:0] code,
    output logic              match
);

    assign match = (sw == code);

endmodule

// File: rtl/lock_sequencer.sv
// Multi-step code-lock sequencer: collects STEPS code words, opens the lock
// for OPEN_CYC cycles on a full match, and locks out after MAX_FAIL misses.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                CODE_W       = LOCK_CODE_W,
    parameter int                STEPS        = LOCK_STEPS,
    parameter int                MAX_FAIL     = LOCK_MAX_FAIL,
    parameter int                OPEN_CYC     = LOCK_OPEN_CYC,
    parameter int                LOCKOUT_CYC  = LOCK_LOCKOUT_CYC,
    parameter int                ENTRY_TO     = LOCK_ENTRY_TO,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(LOCK_DEFAULT_CODE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CODE_W-1:0]             sw,
    input  logic                          enter,
    input  logic                          clear,
    input  logic                          prog_we,
    input  logic [$clog2(STEPS)-1:0]      prog_idx,
    input  logic [CODE_W-1:0]             prog_data,
    output logic                          unlock,
    output logic                          locked_out,
    output logic [$clog2(STEPS)-1:0]      step,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int STEP_W = $clog2(STEPS);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int ENT_W  = $clog2(ENTRY_TO + 1);
    localparam int OPEN_W = $clog2(OPEN_CYC + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
    localparam logic [ENT_W-1:0]  ENT_LAST  = ENT_W'(ENTRY_TO - 1);
    localparam logic [OPEN_W-1:0] OPEN_LOAD = OPEN_W'(OPEN_CYC);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYC);

    state_t            state;
    logic [CODE_W-1:0] code [STEPS];
    logic [CODE_W-1:0] code_sel;
    logic              match;
    logic [FAIL_W-1:0] fail_next;
    logic [ENT_W-1:0]  ent_tmr;
    logic [OPEN_W-1:0] open_tmr;
    logic [LOCK_W-1:0] lock_tmr;

    // Failure counter stops at MAX_FAIL instead of wrapping.
    function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] v);
        return (v == FAIL_MAX) ? v : v + 1'b1;
    endfunction

    assign fail_next = fail_inc(fail_cnt);

    // Select the code word for the step currently expected.
    always_comb begin
        code_sel = code[0];
        for (int i = 0; i < STEPS; i++) begin
            if (step == STEP_W'(i)) code_sel = code[i];
        end
    end

    code_match #(.CODE_W(CODE_W)) u_match (
        .sw    (sw),
        .code  (code_sel),
        .match (match)
    );

    // Code register file: writable only in IDLE, and only when no entry
    // activity competes for the same cycle; out-of-range indices hit nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) code[i] <= DEFAULT_CODE;
        end else if (state == ST_IDLE && prog_we && !enter && !clear) begin
            for (int i = 0; i < STEPS; i++) begin
                if (prog_idx == STEP_W'(i)) code[i] <= prog_data;
            end
        end
    end

    // Sequencer FSM with entry, open and lockout timers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            step       <= '0;
            fail_cnt   <= '0;
            unlock     <= 1'b0;
            locked_out <= 1'b0;
            ent_tmr    <= '0;
            open_tmr   <= '0;
            lock_tmr   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (clear) begin
                        state   <= ST_IDLE;
                        step    <= '0;
                        ent_tmr <= '0;
                    end else if (state == ST_COLLECT && ent_tmr == ENT_LAST) begin
                        // ENTRY_TO idle cycles have elapsed; an enter arriving
                        // now is already too late.
                        state   <= ST_IDLE;
                        step    <= '0;
                        ent_tmr <= '0;
                    end else if (enter) begin
                        ent_tmr <= '0;
                        if (match && step == STEP_LAST) begin
                            state    <= ST_OPEN;
                            step     <= '0;
                            fail_cnt <= '0;
                            unlock   <= 1'b1;
                            open_tmr <= OPEN_LOAD;
                        end else if (match) begin
                            state <= ST_COLLECT;
                            step  <= step + 1'b1;
                        end else begin
                            step     <= '0;
                            fail_cnt <= fail_next;
                            if (fail_next == FAIL_MAX) begin
                                state      <= ST_LOCKOUT;
                                locked_out <= 1'b1;
                                lock_tmr   <= LOCK_LOAD;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end else if (state == ST_COLLECT) begin
                        ent_tmr <= ent_tmr + 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (open_tmr <= OPEN_W'(1)) begin
                        state    <= ST_IDLE;
                        unlock   <= 1'b0;
                        open_tmr <= '0;
                    end else begin
                        open_tmr <= open_tmr - 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (lock_tmr <= LOCK_W'(1)) begin
                        state      <= ST_IDLE;
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
                        lock_tmr   <= '0;
                    end else begin
                        lock_tmr <= lock_tmr - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer with short sim timers.
module tb_lock_sequencer;
    import lock_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    code_t       sw = '0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic        prog_we = 1'b0;
    logic [1:0]  prog_idx = '0;
    code_t       prog_data = '0;
    logic        unlock;
    logic        locked_out;
    logic [1:0]  step;
    logic [1:0]  fail_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lock_sequencer #(
        .CODE_W      (6),
        .STEPS       (3),
        .MAX_FAIL    (3),
        .OPEN_CYC    (4),
        .LOCKOUT_CYC (8),
        .ENTRY_TO    (16),
        .DEFAULT_CODE(6'b100101)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .enter      (enter),
        .clear      (clear),
        .prog_we    (prog_we),
        .prog_idx   (prog_idx),
        .prog_data  (prog_data),
        .unlock     (unlock),
        .locked_out (locked_out),
        .step       (step),
        .fail_cnt   (fail_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        enter = 1'b0;
        clear = 1'b0;
        prog_we = 1'b0;
        cyc(n);
    endtask

    task automatic press(input code_t v);
        sw = v;
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
    endtask

    task automatic prog(input logic [1:0] idx, input code_t d);
        prog_we = 1'b1;
        prog_idx = idx;
        prog_data = d;
        cyc(1);
        prog_we = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("rst_unlock", unlock, 0);
        chk("rst_locked", locked_out, 0);
        chk("rst_step", step, 0);
        chk("rst_fail", fail_cnt, 0);
        rst_n = 1'b1;
        cyc(1);

        // Program and open
        prog(2'd0, 6'h2C);
        prog(2'd1, 6'h15);
        prog(2'd2, 6'h3F);
        press(6'h2C); chk("open_step1", step, 1);
        press(6'h15); chk("open_step2", step, 2);
        press(6'h3F); chk("open_step0", step, 0);
        chk("open_rise", unlock, 1);
        prog(2'd0, 6'h00);            chk("open_hold1", unlock, 1);
        press(6'h2C);                 chk("open_enter_ign", step, 0);
        idle(1);                      chk("open_hold3", unlock, 1);
        idle(1);                      chk("open_end", unlock, 0);
        press(6'h2C);                 chk("open_prog_ign", step, 1);
        press(6'h15);
        press(6'h3F);                 chk("reopen", unlock, 1);
        idle(4);                      chk("reopen_end", unlock, 0);

        // Failures and lockout
        press(6'h2C);                 chk("fail_step1", step, 1);
        press(6'h00);                 chk("fail1_step", step, 0);
        chk("fail1_cnt", fail_cnt, 1);
        chk("fail1_unlock", unlock, 0);
        press(6'h01);                 chk("fail2_cnt", fail_cnt, 2);
        press(6'h02);                 chk("fail3_cnt", fail_cnt, 3);
        chk("lock_rise", locked_out, 1);
        sw = 6'h2C; enter = 1'b1;
        cyc(6);
        enter = 1'b0;
        chk("lock_hold", locked_out, 1);
        chk("lock_step", step, 0);
        chk("lock_fail", fail_cnt, 3);
        idle(1);                      chk("lock_last", locked_out, 1);
        idle(1);                      chk("lock_end", locked_out, 0);
        chk("lock_fail_clr", fail_cnt, 0);
        press(6'h2C);
        press(6'h15);
        press(6'h3F);                 chk("post_lock_open", unlock, 1);
        idle(4);

        // Entry timeout
        press(6'h2C);
        idle(14);
        press(6'h15);                 chk("to_edge_accept", step, 2);
        idle(15);                     chk("to_hold", step, 2);
        idle(1);                      chk("to_fire", step, 0);
        chk("to_fail_keep", fail_cnt, 0);
        press(6'h15);                 chk("to_then_miss", fail_cnt, 1);

        // Programming guards
        press(6'h2C);
        prog(2'd1, 6'h00);            chk("prog_collect_step", step, 1);
        press(6'h15);                 chk("prog_collect_ign", step, 2);
        press(6'h3F);                 chk("prog_collect_open", unlock, 1);
        chk("open_fail_clr", fail_cnt, 0);
        idle(4);
        prog_we = 1'b1; prog_idx = 2'd0; prog_data = 6'h11;
        sw = 6'h2C; enter = 1'b1;
        cyc(1);
        prog_we = 1'b0; enter = 1'b0;
        chk("prog_enter_old", step, 1);
        do_clear();                   chk("clear_step", step, 0);
        press(6'h11);                 chk("prog_dropped", fail_cnt, 1);

        // Clear beats enter
        press(6'h2C);
        clear = 1'b1; enter = 1'b1; sw = 6'h15;
        cyc(1);
        clear = 1'b0; enter = 1'b0;
        chk("clr_enter_step", step, 0);
        chk("clr_enter_fail", fail_cnt, 1);

        // Write visible next cycle; out-of-range index ignored
        prog(2'd0, 6'h11);
        press(6'h11);                 chk("prog_next", step, 1);
        do_clear();
        prog(2'd3, 6'h00);
        press(6'h11);
        press(6'h15);
        press(6'h3F);                 chk("oor_idx_open", unlock, 1);

        // Reset while open
        rst_n = 1'b0;
        #1;
        chk("rst_open_unlock", unlock, 0);
        chk("rst_open_step", step, 0);
        cyc(1);
        rst_n = 1'b1;
        press(6'h25);                 chk("rst_default_step", step, 1);
        press(6'h25);
        press(6'h25);                 chk("rst_default_open", unlock, 1);
        idle(4);

        // Reset during lockout
        press(6'h00);
        press(6'h00);
        press(6'h00);                 chk("lock2_rise", locked_out, 1);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("rst_lock_out", locked_out, 0);
        chk("rst_lock_fail", fail_cnt, 0);
        cyc(1);
        rst_n = 1'b1;
        press(6'h25);
        press(6'h25);
        press(6'h25);                 chk("rst_lock_open", unlock, 1);
        idle(4);                      chk("final_close", unlock, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
